// File: rtl/wb_bram_slave.sv
// Wishbone classic slave in front of a single-port 32-bit block RAM.
// Decodes the RAM window, issues byte-lane writes, waits out the BRAM read
// latency, answers out-of-window accesses with err and keeps debug counters.
module wb_bram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 512,
  parameter int unsigned AW        = 9,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic          wbs_we_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [3:0]    wbs_sel_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   err_cnt
);

  typedef enum logic [1:0] {StIdle, StRdWait, StAck, StErr} state_e;

  // Window size in bytes; 33 bits so a window reaching 4 GiB still compares correctly.
  localparam logic [32:0] WinBytes = 33'(MEM_WORDS) * 33'd4;
  localparam logic [1:0]  RdLat    = 2'(RD_LAT);

  state_e          state_q, state_d;
  logic [1:0]      lat_q, lat_d;
  logic            rd_q, rd_d;
  logic [31:0]     dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            mem_en_q, mem_en_d;
  logic [3:0]      mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_din_q, mem_din_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [15:0]     rd_cnt_q, rd_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic [32:0]     diff;
  logic            in_range;

  // Address decode: a borrow out of the subtraction means below the window.
  always_comb begin
    diff     = {1'b0, wbs_adr_i} - {1'b0, BASE_ADDR};
    in_range = !diff[32] && ({1'b0, diff[31:0]} < WinBytes);
  end

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    rd_d       = rd_q;
    dat_d      = dat_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    mem_en_d   = 1'b0;
    mem_we_d   = 4'b0000;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    err_cnt_d  = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (!in_range) begin
            state_d   = StErr;
            err_cnt_d = err_cnt_q + 16'd1;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = diff[AW+1:2];
            rd_d       = !wbs_we_i;
            if (wbs_we_i) begin
              mem_we_d  = wbs_sel_i;
              mem_din_d = wbs_dat_i;
              state_d   = StAck;
            end else begin
              lat_d   = RdLat;
              state_d = StRdWait;
            end
          end
        end
      end
      StRdWait: begin
        // Master gave up the cycle: drop the read silently.
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (lat_q == 2'd1) begin
          state_d = StAck;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      StAck: begin
        ack_d   = 1'b1;
        state_d = StIdle;
        // Read data becomes valid on the same edge the ack is registered.
        if (rd_q) begin
          dat_d    = mem_dout;
          rd_cnt_d = rd_cnt_q + 16'd1;
        end else begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end
      StErr: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lat_q      <= 2'd0;
      rd_q       <= 1'b0;
      dat_q      <= 32'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 4'b0000;
      mem_addr_q <= '0;
      mem_din_q  <= 32'd0;
      wr_cnt_q   <= 16'd0;
      rd_cnt_q   <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      rd_q       <= rd_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_wb_bram_slave.sv
// Bench for wb_bram_slave: two instances (read latency 1 and 2), each with a
// behavioural BRAM, checked against a word-array reference model.
module tb_wb_bram_slave;

  localparam int unsigned Words = 512;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [31:0] adr   [2];
  logic [31:0] wdat  [2];
  logic [3:0]  sel   [2];
  logic [31:0] rdat  [2];
  logic        ack   [2];
  logic        err   [2];
  logic        men   [2];
  logic [3:0]  mwe   [2];
  logic [8:0]  maddr [2];
  logic [31:0] mdin  [2];
  logic [15:0] wrc   [2];
  logic [15:0] rdc   [2];
  logic [15:0] errc  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = g + 1;
    logic [31:0] bram [Words];
    logic [31:0] p1, p2, dout;

    initial begin
      for (int i = 0; i < int'(Words); i++) bram[i] = 32'd0;
      p1 = 32'd0;
      p2 = 32'd0;
    end

    // Behavioural single-port BRAM with 1- or 2-cycle read latency.
    always @(posedge clk) begin
      if (men[g]) begin
        for (int b = 0; b < 4; b++)
          if (mwe[g][b]) bram[maddr[g]][8*b +: 8] <= mdin[g][8*b +: 8];
        p1 <= bram[maddr[g]];
      end
      p2 <= p1;
    end
    assign dout = (Lat == 1) ? p1 : p2;

    wb_bram_slave #(
      .BASE_ADDR(32'h0000_0000),
      .MEM_WORDS(Words),
      .AW       (9),
      .RD_LAT   (Lat)
    ) u_dut (
      .sys_clk  (clk),
      .rst      (rst[g]),
      .wbs_cyc_i(cyc[g]),
      .wbs_stb_i(stb[g]),
      .wbs_adr_i(adr[g]),
      .wbs_we_i (we[g]),
      .wbs_dat_i(wdat[g]),
      .wbs_sel_i(sel[g]),
      .wbs_dat_o(rdat[g]),
      .wbs_ack_o(ack[g]),
      .wbs_err_o(err[g]),
      .mem_en   (men[g]),
      .mem_we   (mwe[g]),
      .mem_addr (maddr[g]),
      .mem_din  (mdin[g]),
      .mem_dout (dout),
      .wr_cnt   (wrc[g]),
      .rd_cnt   (rdc[g]),
      .err_cnt  (errc[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: word contents and transaction counts per instance.
  logic [31:0] ref_mem [2][Words];
  int          exp_wr  [2];
  int          exp_rd  [2];
  int          exp_er  [2];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] dat;
    logic [3:0]  s;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_counters(input int d);
    chk("wr_cnt", {16'd0, wrc[d]}, 32'(exp_wr[d] % 65536));
    chk("rd_cnt", {16'd0, rdc[d]}, 32'(exp_rd[d] % 65536));
    chk("err_cnt", {16'd0, errc[d]}, 32'(exp_er[d] % 65536));
  endtask

  task automatic check_zero(input int d);
    chk("rst_dat", rdat[d], 32'd0);
    chk("rst_ack", {31'd0, ack[d]}, 32'd0);
    chk("rst_err", {31'd0, err[d]}, 32'd0);
    chk("rst_mem_en", {31'd0, men[d]}, 32'd0);
    chk("rst_mem_we", {28'd0, mwe[d]}, 32'd0);
    chk("rst_mem_addr", {23'd0, maddr[d]}, 32'd0);
    chk("rst_mem_din", mdin[d], 32'd0);
    exp_wr[d] = 0;
    exp_rd[d] = 0;
    exp_er[d] = 0;
    check_counters(d);
  endtask

  // One complete Wishbone transfer; starts and ends 1 time unit after a rising edge.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                     input logic [3:0] s, output logic [31:0] rd, output logic got_err);
    bit          in_rng;
    int          widx, exp_lat, k, en_cnt;
    bit          done, bad_we, both, got_ack;
    logic [31:0] merged;
    in_rng  = longint'(a) < longint'(4 * Words);
    widx    = int'((a >> 2) % Words);
    exp_lat = (!in_rng || w) ? 2 : 2 + d + 1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dat; sel[d] = s;
    k = 0; en_cnt = 0; done = 0; bad_we = 0; both = 0; got_ack = 0; got_err = 0;
    while (!done && k < 12) begin
      @(posedge clk); #1;
      k++;
      if (men[d]) en_cnt++;
      if (k == 1 && in_rng) begin
        chk("issue_mem_addr", {23'd0, maddr[d]}, 32'(widx));
        chk("issue_mem_we", {28'd0, mwe[d]}, w ? {28'd0, s} : 32'd0);
        if (w) chk("issue_mem_din", mdin[d], dat);
      end
      if (k != 1 && mwe[d] != 4'd0) bad_we = 1;
      if (ack[d] && err[d]) both = 1;
      if (ack[d] || err[d]) begin
        done = 1; got_ack = ack[d]; got_err = err[d];
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    rd = rdat[d];
    chk("resp_kind", {30'd0, got_ack, got_err}, in_rng ? 32'd2 : 32'd1);
    chk("latency", 32'(k), 32'(exp_lat));
    chk("mem_en_pulses", 32'(en_cnt), in_rng ? 32'd1 : 32'd0);
    chk("mem_we_stray", {31'd0, bad_we}, 32'd0);
    chk("ack_err_excl", {31'd0, both}, 32'd0);
    if (!in_rng) begin
      exp_er[d]++;
    end else if (w) begin
      merged = ref_mem[d][widx];
      for (int b = 0; b < 4; b++) if (s[b]) merged[8*b +: 8] = dat[8*b +: 8];
      ref_mem[d][widx] = merged;
      exp_wr[d]++;
    end else begin
      chk("read_data", rd, ref_mem[d][widx]);
      exp_rd[d]++;
    end
    check_counters(d);
    @(posedge clk); #1;
    chk("pulse_one_cycle", {30'd0, ack[d], err[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          acks;
    bit          saw;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = 32'd0; wdat[d] = 32'd0; sel[d] = 4'd0;
      for (int i = 0; i < int'(Words); i++) ref_mem[d][i] = 32'd0;
    end

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDE22_BE44};
    tbl[4] = '{1'b0, 32'h0000_0800, 32'h0,         4'hF, 1'b1, 32'h0};
    tbl[5] = '{1'b1, 32'h0000_07FC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h0000_07FC, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
    tbl[7] = '{1'b1, 32'h0000_0012, 32'hAAAA_AAAA, 4'h0, 1'b0, 32'h0};
    tbl[8] = '{1'b0, 32'h0000_0013, 32'h0,         4'hF, 1'b0, 32'hDE22_BE44};
    tbl[9] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 1'b1, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_zero(d);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Directed table on both latency variants.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        txn(d, tbl[i].w, tbl[i].a, tbl[i].dat, tbl[i].s, rd, e);
        chk("tbl_err", {31'd0, e}, {31'd0, tbl[i].exp_err});
        if (!tbl[i].w && !tbl[i].exp_err) chk("tbl_rdata", rd, tbl[i].exp_rdata);
      end
    end

    // Strobe held through ack: each return to idle samples a fresh write.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20;
    wdat[0] = 32'h5A5A_1234; sel[0] = 4'hF;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[0]) acks++;
    end
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    ref_mem[0][8] = 32'h5A5A_1234;
    exp_wr[0] += 3;
    chk("b2b_acks", 32'(acks), 32'd3);
    @(posedge clk); #1;
    check_counters(0);

    // Abort during read wait (latency 2): no ack, no count, next read still works.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    saw = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) saw = 1;
    end
    chk("abort_no_ack", {31'd0, saw}, 32'd0);
    check_counters(1);
    txn(1, 1'b0, 32'h10, 32'h0, 4'hF, rd, e);

    // Reset during read wait clears every output on the next edge.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h7FC;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    check_zero(1);
    cyc[1] = 1'b0; stb[1] = 1'b0; rst[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) saw = 1;
    end
    chk("rst_drops_txn", {31'd0, saw}, 32'd0);
    txn(1, 1'b0, 32'h7FC, 32'h0, 4'hF, rd, e);

    // Randomised traffic against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        logic        w;
        logic [31:0] a;
        w = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) a = $urandom_range(32'd2048, 32'hFFFF_FFFF);
        else a = 32'($urandom_range(0, Words - 1)) * 32'd4 + 32'($urandom_range(0, 3));
        txn(d, w, a, $urandom, 4'($urandom_range(0, 15)), rd, e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
